spi_reg_host: RTL and testbench
===============================

// Module: spi_reg_host
// PURPOSE
//   SPI initiator for the peripheral-harness register port: turns one parallel register
//   read/write request into one SPI frame to an spi_reg responder and returns the read byte.
//   Lives on the test/host side (FPGA harness or loopback bench) and drives uio_in[6:4],
//   sampling uio_out[3]. Mode 0, MSB first, one frame per transaction.
// PARAMETERS
//   ADDR_W   4  register address width; legal range 1..7, zero-extended into frame bits 14:8
//   CLK_DIV  4  clk cycles per SPI half-period; legal minimum 4 (responder synchronises 2 stages)
//   CS_GAP   2  idle half-periods with spi_cs_n high between frames
// PORTS
//   clk        in   1       system clock
//   rst_n      in   1       asynchronous active-low reset
//   req_valid  in   1       request present
//   req_ready  out  1       host can accept; high only in IDLE
//   req_write  in   1       1 = write, 0 = read
//   req_addr   in   ADDR_W  register address
//   req_wdata  in   8       write data (ignored for reads)
//   rsp_valid  out  1       one-cycle pulse: frame complete
//   rsp_rdata  out  8       byte captured from spi_miso (reads only)
//   busy       out  1       high from accept until return to IDLE
//   spi_cs_n   out  1       chip select, active low
//   spi_clk    out  1       serial clock, idles low
//   spi_mosi   out  1       serial data to responder
//   spi_miso   in   1       serial data from responder (synchronised internally, 2 flops)
// BEHAVIOUR
//   Reset: spi_cs_n=1, spi_clk=0, spi_mosi=0, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0;
//     all state returns to IDLE immediately and asynchronously.
//   Frame (16 bits, MSB first): bit15 = req_write, bits14:8 = {0, req_addr}, bits7:0 = req_wdata (0 on read).
//   Accept: req_valid && req_ready at a rising clk edge latches write/addr/wdata; req_ready drops next cycle.
//   FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//     SETUP: spi_cs_n=0, spi_mosi=bit15, spi_clk=0 for CLK_DIV cycles.
//     SHIFT: 16 bits; per bit spi_clk high CLK_DIV cycles then low CLK_DIV cycles; spi_mosi
//       updates only on the falling spi_clk transition, stable through the high phase.
//     Read capture: bits 7:0 sample synchronised spi_miso in the last clk cycle of each high
//       phase; shifted into an internal register, copied to rsp_rdata at frame end.
//     HOLD: spi_clk=0, spi_cs_n=0 for CLK_DIV cycles after last falling edge.
//     GAP: spi_cs_n=1, spi_mosi=0 for CS_GAP*CLK_DIV cycles; rsp_valid pulses on first GAP cycle.
//   Latency: rsp_valid asserts exactly 34*CLK_DIV+1 clk cycles after the accepting edge;
//     next accept possible (34+CS_GAP)*CLK_DIV+1 cycles after the previous one.
//   Writes: rsp_valid pulses, rsp_rdata keeps previous value.
//   req_valid while busy: ignored, no queueing; request inputs may change freely after accept.
//   Divider counter and 5-bit bit counter reload at state entry; no wrap beyond 16 bits.
//   Reset mid-frame: spi_cs_n rises asynchronously, no rsp_valid for the aborted frame.
//   busy = !req_ready at all times.
// TESTING
//   Write 0x5A to addr 0x3, CLK_DIV=4 -> MOSI bits 1,000_0011,0101_1010; 16 spi_clk rises;
//     rsp_valid at cycle 137 after accept; responder reg 3 = 0x5A.
//   Read addr 0x3 after the write, responder model returns 0x5A -> rsp_rdata=0x5A,
//     frame bit15=0, data bits on MOSI all 0.
//   Back-to-back: req_valid held high for two writes -> second accept exactly 145 cycles after
//     first; spi_cs_n high for 8 cycles between frames.
//   req_valid pulsed during SHIFT with different addr -> ignored, frame unchanged, single rsp_valid.
//   rst_n low at bit 9 of a read -> spi_cs_n=1, spi_clk=0 same cycle; no rsp_valid; fresh read
//     after release completes correctly.
//   CLK_DIV=8, read returning 0x81 -> spi_clk half-period 8 cycles, rsp_rdata=0x81, latency 273.

Source files
------------

// File: rtl/spi_reg_host.sv
// SPI initiator for the register port of an spi_reg responder.
// Turns one parallel read/write request into one 16-bit mode-0 frame, MSB first,
// and returns the byte captured from spi_miso on reads.
module spi_reg_host #(
    parameter int ADDR_W  = 4,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              busy,
    output logic              spi_cs_n,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int GAP_CYC = CS_GAP * CLK_DIV;
    localparam int CNT_TOP = (GAP_CYC > CLK_DIV) ? GAP_CYC : CLK_DIV;
    localparam int CNT_W   = $clog2(CNT_TOP + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [4:0]        bit_cnt;
    logic [15:0]       tx_sh;
    logic [7:0]        rx_sh;
    logic              is_write;
    logic              miso_meta;
    logic              miso_sync;
    logic              half_done;
    logic              gap_done;
    logic [15:0]       frame;

    // Frame layout: command bit, zero-extended address, data byte (zero on reads)
    assign frame     = {req_write, 7'(req_addr), req_write ? req_wdata : 8'h00};
    assign half_done = (cnt == HALF_LAST);
    assign gap_done  = (cnt == GAP_LAST);
    assign req_ready = (state == ST_IDLE);
    assign busy      = ~req_ready;

    // Two-flop synchroniser for the responder's data line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
        end else begin
            miso_meta <= spi_miso;
            miso_sync <= miso_meta;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: each phase ends when the divider counter reaches its last cycle
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (req_valid) state_next = ST_SETUP;
            ST_SETUP: if (half_done) state_next = ST_SHIFT;
            ST_SHIFT: if (half_done && !spi_clk && (bit_cnt == 5'd16)) state_next = ST_HOLD;
            ST_HOLD:  if (half_done) state_next = ST_GAP;
            ST_GAP:   if (gap_done) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Datapath: divider, serial clock/data generation, read capture and response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bit_cnt   <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            is_write  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            spi_cs_n  <= 1'b1;
            spi_clk   <= 1'b0;
            spi_mosi  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;

            // Divider restarts on every state entry and on every SCK phase toggle
            if ((state == ST_IDLE) || (state_next != state) ||
                ((state == ST_SHIFT) && half_done)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        is_write <= req_write;
                        tx_sh    <= {frame[14:0], 1'b0};
                        spi_mosi <= frame[15];
                        spi_cs_n <= 1'b0;
                        bit_cnt  <= '0;
                    end
                end
                ST_SETUP: begin
                    if (half_done) spi_clk <= 1'b1;
                end
                ST_SHIFT: begin
                    if (half_done) begin
                        if (spi_clk) begin
                            // Falling edge: advance MOSI, capture data-phase bits
                            spi_clk  <= 1'b0;
                            spi_mosi <= tx_sh[15];
                            tx_sh    <= {tx_sh[14:0], 1'b0};
                            bit_cnt  <= bit_cnt + 5'd1;
                            if (bit_cnt >= 5'd8) rx_sh <= {rx_sh[6:0], miso_sync};
                        end else if (bit_cnt != 5'd16) begin
                            spi_clk <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (half_done) begin
                        spi_cs_n  <= 1'b1;
                        spi_mosi  <= 1'b0;
                        rsp_valid <= 1'b1;
                        if (!is_write) rsp_rdata <= rx_sh;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_host.sv
// Directed bench for spi_reg_host: two hosts (CLK_DIV 4 and 8) each talking to a
// behavioural spi_reg responder with a 16-entry register file.
module tb_spi_reg_host;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_valid = '0;
    logic [1:0] req_write = '0;
    logic [3:0] req_addr  [2] = '{4'h0, 4'h0};
    logic [7:0] req_wdata [2] = '{8'h00, 8'h00};
    logic [1:0] req_ready;
    logic [1:0] rsp_valid;
    logic [7:0] rsp_rdata [2];
    logic [1:0] busy;
    logic [1:0] spi_cs_n;
    logic [1:0] spi_clk;
    logic [1:0] spi_mosi;
    logic [1:0] spi_miso;
    logic [15:0] last_frame [2];
    logic [4:0]  last_bits  [2];
    int          mosi_viol  [2];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_unit
        localparam int CD = (gi == 0) ? 4 : 8;

        spi_reg_host #(.ADDR_W(4), .CLK_DIV(CD), .CS_GAP(2)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[gi]),
            .req_ready (req_ready[gi]),
            .req_write (req_write[gi]),
            .req_addr  (req_addr[gi]),
            .req_wdata (req_wdata[gi]),
            .rsp_valid (rsp_valid[gi]),
            .rsp_rdata (rsp_rdata[gi]),
            .busy      (busy[gi]),
            .spi_cs_n  (spi_cs_n[gi]),
            .spi_clk   (spi_clk[gi]),
            .spi_mosi  (spi_mosi[gi]),
            .spi_miso  (spi_miso[gi])
        );

        logic [7:0]  mem [16] = '{default: 8'h00};
        logic        clk_q = 1'b0;
        logic        prev_mosi = 1'b0;
        logic        miso_r = 1'b0;
        logic [4:0]  n = '0;
        logic [15:0] sh = '0;
        logic [7:0]  dsh = '0;
        logic [15:0] frame_q = '0;
        logic [4:0]  bits_q = '0;
        int          viol = 0;

        assign spi_miso[gi]   = miso_r;
        assign last_frame[gi] = frame_q;
        assign last_bits[gi]  = bits_q;
        assign mosi_viol[gi]  = viol;

        // Responder: samples MOSI on SCK rise, drives MISO after SCK fall
        always @(posedge clk) begin
            clk_q     <= spi_clk[gi];
            prev_mosi <= spi_mosi[gi];
            if (spi_clk[gi] && clk_q && !spi_cs_n[gi] && (spi_mosi[gi] !== prev_mosi))
                viol <= viol + 1;
            if (spi_cs_n[gi]) begin
                if (n != 0) begin
                    frame_q <= sh;
                    bits_q  <= n;
                end
                n      <= '0;
                miso_r <= 1'b0;
            end else if (spi_clk[gi] && !clk_q) begin
                sh <= {sh[14:0], spi_mosi[gi]};
                n  <= n + 5'd1;
                if ((n == 5'd15) && sh[14]) mem[sh[10:7]] <= {sh[6:0], spi_mosi[gi]};
            end else if (!spi_clk[gi] && clk_q) begin
                if ((n == 5'd8) && !sh[7]) begin
                    miso_r <= mem[sh[3:0]][7];
                    dsh    <= {mem[sh[3:0]][6:0], 1'b0};
                end else if ((n > 5'd8) && (n < 5'd16)) begin
                    miso_r <= dsh[7];
                    dsh    <= {dsh[6:0], 1'b0};
                end
            end
        end
    end

    // Issue one request and watch it to completion; cycle 1 is the cycle after the accept edge
    task automatic run_txn(input int s, input logic wr, input logic [3:0] a, input logic [7:0] d,
                           output int lat, output int nvalid, output int nhigh, output int ngap);
        lat = -1; nvalid = 0; nhigh = 0; ngap = 0;
        @(negedge clk);
        req_valid[s] = 1'b1; req_write[s] = wr; req_addr[s] = a; req_wdata[s] = d;
        for (int k = 0; k < 400 && !req_ready[s]; k++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        req_valid[s] = 1'b0; req_addr[s] = ~a; req_wdata[s] = ~d;
        for (int c = 1; c <= 600; c++) begin
            if (rsp_valid[s]) begin
                nvalid++;
                if (lat < 0) lat = c;
            end
            if (spi_clk[s]) nhigh++;
            if (spi_cs_n[s] && busy[s]) ngap++;
            if (!busy[s]) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        for (int s = 0; s < 2; s++) begin
            vectors++;
            if ({spi_cs_n[s], spi_clk[s], spi_mosi[s], req_ready[s], busy[s], rsp_valid[s]} !== 6'b100100) begin
                miscompares++;
                $display("FAIL reset_ctrl[%0d]: got %b expected 100100", s,
                         {spi_cs_n[s], spi_clk[s], spi_mosi[s], req_ready[s], busy[s], rsp_valid[s]});
            end
            vectors++;
            if (rsp_rdata[s] !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_rdata[%0d]: got %h expected 00", s, rsp_rdata[s]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        int lat, nv, nh, ng;
        run_txn(0, 1'b1, 4'h3, 8'h5A, lat, nv, nh, ng);
        vectors++;
        if (lat !== 137) begin miscompares++; $display("FAIL write_latency: got %0d expected 137", lat); end
        vectors++;
        if (nv !== 1) begin miscompares++; $display("FAIL write_rsp_count: got %0d expected 1", nv); end
        vectors++;
        if (last_frame[0] !== 16'h835A) begin miscompares++; $display("FAIL write_frame: got %h expected 835a", last_frame[0]); end
        vectors++;
        if (last_bits[0] !== 5'd16) begin miscompares++; $display("FAIL write_sck_rises: got %0d expected 16", last_bits[0]); end
        vectors++;
        if (nh !== 64) begin miscompares++; $display("FAIL write_sck_high: got %0d expected 64", nh); end
        vectors++;
        if (rsp_rdata[0] !== 8'h00) begin miscompares++; $display("FAIL write_rdata_kept: got %h expected 00", rsp_rdata[0]); end
        vectors++;
        if (ng !== 8) begin miscompares++; $display("FAIL write_gap: got %0d expected 8", ng); end
    endtask

    task automatic test_read();
        int lat, nv, nh, ng;
        run_txn(0, 1'b0, 4'h3, 8'hFF, lat, nv, nh, ng);
        vectors++;
        if (lat !== 137) begin miscompares++; $display("FAIL read_latency: got %0d expected 137", lat); end
        vectors++;
        if (rsp_rdata[0] !== 8'h5A) begin miscompares++; $display("FAIL read_rdata: got %h expected 5a", rsp_rdata[0]); end
        vectors++;
        if (last_frame[0] !== 16'h0300) begin miscompares++; $display("FAIL read_frame: got %h expected 0300", last_frame[0]); end
        vectors++;
        if (nv !== 1) begin miscompares++; $display("FAIL read_rsp_count: got %0d expected 1", nv); end
    endtask

    task automatic test_back_to_back();
        int acc0, acc1, ngap, lat, nv, nh, ng;
        ngap = 0;
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 4'h1; req_wdata[0] = 8'h11;
        for (int k = 0; k < 400 && !req_ready[0]; k++) @(negedge clk);
        acc0 = cyc + 1;
        acc1 = acc0 - 1000;
        @(posedge clk);
        @(negedge clk);
        req_addr[0] = 4'h2; req_wdata[0] = 8'h22;
        for (int c = 0; c < 400; c++) begin
            if (req_ready[0]) begin
                acc1 = cyc + 1;
                break;
            end
            if (spi_cs_n[0] && busy[0]) ngap++;
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        for (int c = 0; c < 400 && busy[0]; c++) @(negedge clk);
        vectors++;
        if (acc1 - acc0 !== 145) begin miscompares++; $display("FAIL b2b_accept_spacing: got %0d expected 145", acc1 - acc0); end
        vectors++;
        if (ngap !== 8) begin miscompares++; $display("FAIL b2b_cs_gap: got %0d expected 8", ngap); end
        vectors++;
        if (last_frame[0] !== 16'h8222) begin miscompares++; $display("FAIL b2b_second_frame: got %h expected 8222", last_frame[0]); end
        run_txn(0, 1'b0, 4'h1, 8'h00, lat, nv, nh, ng);
        vectors++;
        if (rsp_rdata[0] !== 8'h11) begin miscompares++; $display("FAIL b2b_first_write: got %h expected 11", rsp_rdata[0]); end
    endtask

    task automatic test_ignored_request();
        int nv, cs_low, lat, nh, ng;
        nv = 0; cs_low = 0;
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 4'h6; req_wdata[0] = 8'hC3;
        for (int k = 0; k < 400 && !req_ready[0]; k++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (40) @(negedge clk);
        req_valid[0] = 1'b1; req_addr[0] = 4'h9; req_wdata[0] = 8'h11;
        @(negedge clk);
        req_valid[0] = 1'b0;
        for (int c = 0; c < 400 && busy[0]; c++) begin
            if (rsp_valid[0]) nv++;
            @(negedge clk);
        end
        repeat (20) begin
            if (!spi_cs_n[0] || rsp_valid[0]) cs_low++;
            @(negedge clk);
        end
        vectors++;
        if (nv !== 1) begin miscompares++; $display("FAIL ignore_rsp_count: got %0d expected 1", nv); end
        vectors++;
        if (last_frame[0] !== 16'h86C3) begin miscompares++; $display("FAIL ignore_frame: got %h expected 86c3", last_frame[0]); end
        vectors++;
        if (cs_low !== 0) begin miscompares++; $display("FAIL ignore_no_second_frame: got %0d expected 0", cs_low); end
        run_txn(0, 1'b0, 4'h9, 8'h00, lat, nv, nh, ng);
        vectors++;
        if (rsp_rdata[0] !== 8'h00) begin miscompares++; $display("FAIL ignore_reg9_untouched: got %h expected 00", rsp_rdata[0]); end
    endtask

    task automatic test_reset_mid_frame();
        int rises, nv, lat, nh, ng;
        logic prev;
        rises = 0; nv = 0; prev = 1'b0;
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 4'h3; req_wdata[0] = 8'h00;
        for (int k = 0; k < 400 && !req_ready[0]; k++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        for (int c = 0; c < 400 && rises < 9; c++) begin
            if (spi_clk[0] && !prev) rises++;
            prev = spi_clk[0];
            if (rises < 9) @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({spi_cs_n[0], spi_clk[0], busy[0], rsp_valid[0]} !== 4'b1000) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %b expected 1000", {spi_cs_n[0], spi_clk[0], busy[0], rsp_valid[0]});
        end
        vectors++;
        if (rsp_rdata[0] !== 8'h00) begin miscompares++; $display("FAIL midreset_rdata: got %h expected 00", rsp_rdata[0]); end
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid[0]) nv++;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid[0]) nv++;
        end
        vectors++;
        if (nv !== 0) begin miscompares++; $display("FAIL midreset_no_rsp: got %0d expected 0", nv); end
        run_txn(0, 1'b0, 4'h3, 8'h00, lat, nv, nh, ng);
        vectors++;
        if (rsp_rdata[0] !== 8'h5A) begin miscompares++; $display("FAIL midreset_fresh_read: got %h expected 5a", rsp_rdata[0]); end
        vectors++;
        if (lat !== 137) begin miscompares++; $display("FAIL midreset_fresh_latency: got %0d expected 137", lat); end
    endtask

    task automatic test_clkdiv8();
        int lat, nv, nh, ng;
        run_txn(1, 1'b1, 4'h5, 8'h81, lat, nv, nh, ng);
        vectors++;
        if (lat !== 273) begin miscompares++; $display("FAIL div8_write_latency: got %0d expected 273", lat); end
        vectors++;
        if (last_frame[1] !== 16'h8581) begin miscompares++; $display("FAIL div8_write_frame: got %h expected 8581", last_frame[1]); end
        vectors++;
        if (nh !== 128) begin miscompares++; $display("FAIL div8_sck_high: got %0d expected 128", nh); end
        vectors++;
        if (ng !== 16) begin miscompares++; $display("FAIL div8_gap: got %0d expected 16", ng); end
        run_txn(1, 1'b0, 4'h5, 8'h00, lat, nv, nh, ng);
        vectors++;
        if (lat !== 273) begin miscompares++; $display("FAIL div8_read_latency: got %0d expected 273", lat); end
        vectors++;
        if (rsp_rdata[1] !== 8'h81) begin miscompares++; $display("FAIL div8_read_rdata: got %h expected 81", rsp_rdata[1]); end
        vectors++;
        if (last_frame[1] !== 16'h0500) begin miscompares++; $display("FAIL div8_read_frame: got %h expected 0500", last_frame[1]); end
    endtask

    task automatic test_mosi_stability();
        for (int s = 0; s < 2; s++) begin
            vectors++;
            if (mosi_viol[s] !== 0) begin
                miscompares++;
                $display("FAIL mosi_stable_high[%0d]: got %0d expected 0", s, mosi_viol[s]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_ignored_request();
        test_reset_mid_frame();
        test_clkdiv8();
        test_mosi_stability();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
